// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU_control encodings and the mult/div sequencer state encoding.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_DIV = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b1000;
   localparam logic [3:0] ALU_OR  = 4'b1001;
   localparam logic [3:0] ALU_XOR = 4'b1010;
   localparam logic [3:0] ALU_NOR = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10
   } md_state_e;

   // True when an ALU_control code selects one of the given multi-cycle ops.
   function automatic logic op_matches(input logic [3:0] code,
                                       input logic [3:0] mul_code,
                                       input logic [3:0] div_code);
      return (code == mul_code) || (code == div_code);
   endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
// upper holds acc/remainder, lower holds multiplier/quotient, operand is multiplicand/divisor.
module mul_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             div_mode_i,
   input  logic [WIDTH-1:0] upper_i,
   input  logic [WIDTH-1:0] lower_i,
   input  logic [WIDTH-1:0] operand_i,
   output logic [WIDTH-1:0] upper_o,
   output logic [WIDTH-1:0] lower_o
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] rem_sh_s;
   logic [WIDTH:0] trial_s;

   // Both candidate updates are formed every cycle; the mode picks one.
   always_comb begin
      sum_s    = {1'b0, upper_i} + (lower_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
      rem_sh_s = {upper_i, lower_i[WIDTH-1]};
      trial_s  = rem_sh_s - {1'b0, operand_i};
      upper_o  = {WIDTH{1'b0}};
      lower_o  = {WIDTH{1'b0}};
      if (div_mode_i) begin
         // Top bit of the WIDTH+1 trial is the borrow: clear means remainder >= divisor.
         if (!trial_s[WIDTH]) begin
            upper_o = trial_s[WIDTH-1:0];
            lower_o = {lower_i[WIDTH-2:0], 1'b1};
         end else begin
            upper_o = rem_sh_s[WIDTH-1:0];
            lower_o = {lower_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         upper_o = sum_s[WIDTH:1];
         lower_o = {sum_s[0], lower_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MIPS mult/div controller: iterates WIDTH steps, then writes HI/LO and pulses done.
// Stalls upstream while busy if a new mult/div or an mfhi/mflo shows up.
module mult_div_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter logic [3:0]  MUL_CODE = ALU_MUL,
   parameter logic [3:0]  DIV_CODE = ALU_DIV
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hilo_read,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] upper_q;
   logic [WIDTH-1:0] lower_q;
   logic [WIDTH-1:0] operand_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             done_q;
   logic             dbz_q;

   logic [WIDTH-1:0] upper_d;
   logic [WIDTH-1:0] lower_d;
   logic             accept_s;
   logic             div_zero_s;

   assign accept_s   = start && op_matches(alu_control, MUL_CODE, DIV_CODE);
   assign div_zero_s = (op_b == {WIDTH{1'b0}});

   mul_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .div_mode_i (state_q == ST_DIV),
      .upper_i    (upper_q),
      .lower_i    (lower_q),
      .operand_i  (operand_q),
      .upper_o    (upper_d),
      .lower_o    (lower_d)
   );

   // Sequencer FSM, iteration counter and architectural HI/LO registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         upper_q   <= {WIDTH{1'b0}};
         lower_q   <= {WIDTH{1'b0}};
         operand_q <= {WIDTH{1'b0}};
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  dbz_q <= 1'b0;
                  if (alu_control == MUL_CODE) begin
                     upper_q   <= {WIDTH{1'b0}};
                     lower_q   <= op_b;
                     operand_q <= op_a;
                     cnt_q     <= CNT_INIT;
                     state_q   <= ST_MUL;
                  end else if (div_zero_s) begin
                     // No iteration: report completion with HI/LO left untouched.
                     dbz_q  <= 1'b1;
                     done_q <= 1'b1;
                  end else begin
                     upper_q   <= {WIDTH{1'b0}};
                     lower_q   <= op_a;
                     operand_q <= op_b;
                     cnt_q     <= CNT_INIT;
                     state_q   <= ST_DIV;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               upper_q <= upper_d;
               lower_q <= lower_d;
               cnt_q   <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  hi_q    <= upper_d;
                  lo_q    <= lower_d;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign stall       = busy & (start | hilo_read);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule
